// File: rtl/ctrl_arbiter_pkg.sv
// Shared types for the ctrl_arbiter slice: FSM state encoding used by the
// top level and exposed on its debug port.
package ctrl_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    GUARD = 2'd2
  } arb_state_t;

endpackage : ctrl_arb_pkg

// File: rtl/ctrl_arbiter_if.sv
// Requester-side bundle of the ctrl arbiter: request levels, serial data and
// the one-hot grant returned to the requesters.
interface ctrl_arbiter_if #(
  parameter int N_REQ = 4
);
  // req[i] is a level: held high while requester i wants a frame. gnt[i] is
  // high for exactly one frame; while it is high, req_bit[i] carries that
  // frame's bits, one per cycle. A grant is never withdrawn early, even when
  // req[i] falls mid-frame.
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] req_bit;
  logic [N_REQ-1:0] gnt;

  modport master (
    output req,
    output req_bit,
    input  gnt
  );

  modport slave (
    input  req,
    input  req_bit,
    output gnt
  );

endinterface : ctrl_arbiter_if

// File: rtl/ctrl_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping to the bottom of the vector.
module rr_pick #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] idx
);

  logic [2*N-1:0] dbl;

  // The lower copy hides requesters below ptr, so a hit there wins first;
  // the unmasked upper copy provides the wrapped-around candidates.
  always_comb begin
    dbl   = {req, req};
    valid = |req;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (i < int'(ptr)) begin
        dbl[i] = 1'b0;
      end
    end
    for (int i = 2*N-1; i >= 0; i--) begin
      if (dbl[i]) begin
        idx = (i >= N) ? IW'(i - N) : IW'(i);
      end
    end
  end

endmodule : rr_pick

// File: rtl/ctrl_arbiter.sv
// Round-robin owner of dgtop's serial ctrl input: grants fixed-length frames,
// retimes the owner's bit onto ctrl and idles for GUARD cycles between owners.
module ctrl_arbiter
  import ctrl_arb_pkg::*;
#(
  parameter  int N_REQ     = 4,
  parameter  int FRAME_LEN = 8,
  parameter  int GUARD     = 2,
  localparam int IDX_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int CNT_W     = $clog2(FRAME_LEN + GUARD + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ctrl_arbiter_if.slave        bus,
  output logic                 ctrl,
  output logic [IDX_W-1:0]     owner,
  output logic                 busy,
  output logic                 frame_done,
  output arb_state_t           state_dbg
);

  localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] LAST_GUARD = CNT_W'((GUARD > 0) ? GUARD - 1 : 0);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_REQ - 1);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             ctrl_q, ctrl_d;
  logic             frame_done_q, frame_done_d;

  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;

  rr_pick #(
    .N (N_REQ)
  ) u_pick (
    .req   (bus.req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ptr_d        = ptr_q;
    owner_d      = owner_q;
    gnt_d        = gnt_q;
    ctrl_d       = 1'b0;
    frame_done_d = 1'b0;
    case (state_q)
      ctrl_arb_pkg::IDLE: begin
        if (pick_valid) begin
          state_d           = ctrl_arb_pkg::SEND;
          gnt_d             = '0;
          gnt_d[pick_idx]   = 1'b1;
          owner_d           = pick_idx;
          cnt_d             = '0;
        end
      end
      ctrl_arb_pkg::SEND: begin
        ctrl_d = bus.req_bit[owner_q];
        cnt_d  = cnt_q + CNT_W'(1);
        // Last sample of the frame: drop the grant on the same edge that
        // loads the final bit, so gnt stays up for exactly FRAME_LEN cycles.
        if (cnt_q == LAST_BIT) begin
          gnt_d        = '0;
          frame_done_d = 1'b1;
          cnt_d        = '0;
          ptr_d        = (owner_q == LAST_IDX) ? '0 : owner_q + IDX_W'(1);
          state_d      = (GUARD > 0) ? ctrl_arb_pkg::GUARD : ctrl_arb_pkg::IDLE;
        end
      end
      ctrl_arb_pkg::GUARD: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_GUARD) begin
          state_d = ctrl_arb_pkg::IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ctrl_arb_pkg::IDLE;
        gnt_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ctrl_arb_pkg::IDLE;
      cnt_q        <= '0;
      ptr_q        <= '0;
      owner_q      <= '0;
      gnt_q        <= '0;
      ctrl_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ptr_q        <= ptr_d;
      owner_q      <= owner_d;
      gnt_q        <= gnt_d;
      ctrl_q       <= ctrl_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.gnt    = gnt_q;
  assign ctrl       = ctrl_q;
  assign owner      = owner_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q != ctrl_arb_pkg::IDLE);
  assign state_dbg  = state_q;

endmodule : ctrl_arbiter

// File: tb/tb_ctrl_arbiter.sv
// Bench for ctrl_arbiter (N_REQ=4, FRAME_LEN=8, GUARD=2): frame table plus
// hand-written reset sequences, with a queue of expected ctrl bits.
module tb_ctrl_arbiter;
  import ctrl_arb_pkg::*;

  localparam int W = 1;

  logic       clk;
  logic       rst_n;
  logic       ctrl;
  logic [1:0] owner;
  logic       busy;
  logic       frame_done;
  arb_state_t state_dbg;

  ctrl_arbiter_if #(.N_REQ(4)) bus ();

  ctrl_arbiter #(
    .N_REQ     (4),
    .FRAME_LEN (8),
    .GUARD     (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .ctrl       (ctrl),
    .owner      (owner),
    .busy       (busy),
    .frame_done (frame_done),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  // scoreboard
  logic [W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int last_gnt_cyc = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got=%0h expected=%0h", name, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    check("gnt_onehot", 32'($countones(bus.gnt) <= 1), 32'd1);
  end

  typedef struct {
    logic [3:0] req;
    logic [7:0] bits;
    int         exp_owner;
    int         drop_after;
    bit         chk_gap;
  } vec_t;

  vec_t vecs[9];

  // One full grant: request, FRAME_LEN bits, two guard cycles.
  task automatic run_frame(input logic [3:0] r, input logic [7:0] bits,
                           input int exp_own, input int drop_after, input bit chk_gap);
    logic [3:0]   onehot;
    logic [3:0]   rb;
    logic [W-1:0] exp_bit;
    onehot = 4'b0001 << exp_own;
    bus.req = r;
    @(posedge clk); #1;
    check("grant", 32'(bus.gnt), 32'(onehot));
    check("owner", 32'(owner), 32'(exp_own));
    check("busy_send", 32'(busy), 32'd1);
    check("ctrl_at_grant", 32'(ctrl), 32'd0);
    if (chk_gap) check("grant_spacing", 32'(cycle - last_gnt_cyc), 32'd11);
    last_gnt_cyc = cycle;
    for (int k = 0; k < 8; k++) begin
      if (k == drop_after) bus.req[exp_own] = 1'b0;
      rb = 4'($urandom_range(0, 15));
      rb[exp_own] = bits[k];
      bus.req_bit = rb;
      exp_q.push_back(bits[k]);
      @(posedge clk); #1;
      exp_bit = exp_q.pop_front();
      check("ctrl_bit", 32'(ctrl), 32'(exp_bit));
      check("gnt_hold", 32'(bus.gnt), (k < 7) ? 32'(onehot) : 32'd0);
      check("frame_done", 32'(frame_done), (k == 7) ? 32'd1 : 32'd0);
    end
    bus.req_bit = 4'($urandom_range(0, 15));
    @(posedge clk); #1;
    check("guard1_ctrl", 32'(ctrl), 32'd0);
    check("guard1_busy", 32'(busy), 32'd1);
    check("guard1_fd", 32'(frame_done), 32'd0);
    check("guard1_gnt", 32'(bus.gnt), 32'd0);
    @(posedge clk); #1;
    check("guard2_ctrl", 32'(ctrl), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("owner_hold", 32'(owner), 32'(exp_own));
  endtask

  initial begin
    vecs[0] = '{4'b1111, 8'($urandom_range(0, 255)), 0, 8, 1'b0};
    vecs[1] = '{4'b1111, 8'($urandom_range(0, 255)), 1, 8, 1'b1};
    vecs[2] = '{4'b1111, 8'($urandom_range(0, 255)), 2, 8, 1'b1};
    vecs[3] = '{4'b1111, 8'($urandom_range(0, 255)), 3, 8, 1'b1};
    vecs[4] = '{4'b1111, 8'($urandom_range(0, 255)), 0, 8, 1'b1};
    vecs[5] = '{4'b0100, 8'b0100_1101,              2, 8, 1'b1};
    vecs[6] = '{4'b0010, 8'($urandom_range(0, 255)), 1, 3, 1'b1};
    vecs[7] = '{4'b1001, 8'($urandom_range(0, 255)), 3, 8, 1'b1};
    vecs[8] = '{4'b1001, 8'($urandom_range(0, 255)), 0, 8, 1'b1};

    rst_n = 1'b0;
    bus.req = 4'b1111;
    bus.req_bit = 4'b0000;
    #7;
    check("rst_gnt", 32'(bus.gnt), 32'd0);
    check("rst_ctrl", 32'(ctrl), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fd", 32'(frame_done), 32'd0);
    check("rst_owner", 32'(owner), 32'd0);
    #4;
    check("rst_gnt_late", 32'(bus.gnt), 32'd0);
    check("rst_busy_late", 32'(busy), 32'd0);
    #1 rst_n = 1'b1;

    for (int v = 0; v < 9; v++) begin
      run_frame(vecs[v].req, vecs[v].bits, vecs[v].exp_owner,
                vecs[v].drop_after, vecs[v].chk_gap);
    end

    // Reset in the middle of owner 3's frame.
    bus.req = 4'b1000;
    @(posedge clk); #1;
    check("mid_grant", 32'(bus.gnt), 32'b1000);
    for (int k = 0; k < 4; k++) begin
      bus.req_bit = 4'b1000;
      @(posedge clk); #1;
    end
    check("mid_ctrl_before", 32'(ctrl), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_gnt", 32'(bus.gnt), 32'd0);
    check("mid_rst_ctrl", 32'(ctrl), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_owner", 32'(owner), 32'd0);
    @(posedge clk); #1;
    check("mid_rst_fd", 32'(frame_done), 32'd0);
    @(negedge clk); #2 rst_n = 1'b1;

    run_frame(4'b1001, 8'($urandom_range(0, 255)), 0, 8, 1'b0);
    run_frame(4'b1001, 8'($urandom_range(0, 255)), 3, 8, 1'b1);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_ctrl_arbiter
